// File: rtl/comparator_bist_if.sv
// Bus between the comparator BIST engine and its environment: the DUT operand/result
// pair and the run control/status readout.
interface comparator_bist_if #(
   parameter int S      = 8,
   parameter int SETTLE = 4,
   parameter int ERR_W  = 21
);
   localparam int MS_W = $clog2(SETTLE + 2);

   logic              start;
   logic [S-1:0]      dut_a;
   logic [S-1:0]      dut_b;
   logic              dut_eq;
   logic              dut_gt;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ERR_W-1:0]  err_count;
   logic              fail_valid;
   logic [S-1:0]      first_fail_a;
   logic [S-1:0]      first_fail_b;
   logic [MS_W-1:0]   max_settle;

   modport master (
      input  start, dut_eq, dut_gt,
      output dut_a, dut_b, busy, done, pass, err_count,
             fail_valid, first_fail_a, first_fail_b, max_settle
   );

   modport slave (
      output start, dut_eq, dut_gt,
      input  dut_a, dut_b, busy, done, pass, err_count,
             fail_valid, first_fail_a, first_fail_b, max_settle
   );
endinterface

// File: rtl/comparator_bist.sv
// Exhaustive BIST for an S-bit EQ/GT comparator: sweeps every {a,b} pair, samples the
// DUT SETTLE times per vector, counts failures and tracks worst-case settle time.
module comparator_bist #(
   parameter int S      = 8,
   parameter int SETTLE = 4,
   parameter int ERR_W  = 21
) (
   input  logic                clk,
   input  logic                reset,
   comparator_bist_if.master   bus
);
   localparam int VW   = 2 * S;
   localparam int KW   = $clog2(SETTLE + 1);
   localparam int MS_W = $clog2(SETTLE + 2);

   typedef enum logic [1:0] {IDLE, APPLY, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [VW-1:0]     vec_q, vec_d;
   logic [KW-1:0]     k_q, k_d;
   logic [KW-1:0]     lm_q, lm_d;
   logic [S-1:0]      a_q, a_d;
   logic [S-1:0]      b_q, b_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              fv_q, fv_d;
   logic [S-1:0]      ffa_q, ffa_d;
   logic [S-1:0]      ffb_q, ffb_d;
   logic [MS_W-1:0]   max_q, max_d;

   logic              exp_eq;
   logic              exp_gt;
   logic              mismatch;
   logic [MS_W-1:0]   settle;

   assign exp_eq   = (a_q == b_q);
   assign exp_gt   = (a_q > b_q);
   assign mismatch = (bus.dut_eq != exp_eq) || (bus.dut_gt != exp_gt);
   // Settle is one past the last sample that was still wrong.
   assign settle   = MS_W'(lm_q) + MS_W'(1);

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      k_d     = k_q;
      lm_d    = lm_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      fv_d    = fv_q;
      ffa_d   = ffa_q;
      ffb_d   = ffb_q;
      max_d   = max_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = APPLY;
               vec_d   = '0;
               err_d   = '0;
               fv_d    = 1'b0;
               max_d   = '0;
            end
         end
         APPLY: begin
            a_d     = vec_q[VW-1:S];
            b_d     = vec_q[S-1:0];
            k_d     = KW'(1);
            lm_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mismatch) begin
               lm_d = k_q;
            end
            if (k_q == KW'(SETTLE)) begin
               if (mismatch) begin
                  if (err_q != '1) begin
                     err_d = err_q + ERR_W'(1);
                  end
                  if (!fv_q) begin
                     fv_d  = 1'b1;
                     ffa_d = a_q;
                     ffb_d = b_q;
                  end
               end else if (settle > max_q) begin
                  max_d = settle;
               end
               if (vec_q == '1) begin
                  state_d = DONE;
               end else begin
                  vec_d   = vec_q + VW'(1);
                  state_d = APPLY;
               end
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= '0;
         k_q     <= '0;
         lm_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         ffa_q   <= '0;
         ffb_q   <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         k_q     <= k_d;
         lm_q    <= lm_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         ffa_q   <= ffa_d;
         ffb_q   <= ffb_d;
         max_q   <= max_d;
      end
   end

   assign bus.dut_a        = a_q;
   assign bus.dut_b        = b_q;
   assign bus.busy         = (state_q == APPLY) || (state_q == WAIT);
   assign bus.done         = (state_q == DONE);
   assign bus.pass         = (state_q == DONE) && (err_q == '0);
   assign bus.err_count    = err_q;
   assign bus.fail_valid   = fv_q;
   assign bus.first_fail_a = ffa_q;
   assign bus.first_fail_b = ffb_q;
   assign bus.max_settle   = max_q;
endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist (S=2, SETTLE=3) driving a configurable comparator
// (optional GT stuck-at-0, 0..3 register stages) and checking against a run model.
module tb_comparator_bist;
   localparam int S      = 2;
   localparam int SETTLE = 3;
   localparam int ERR_W  = 21;
   localparam int NV     = 1 << (2 * S);
   localparam int P      = SETTLE + 1;
   localparam int MASK   = (1 << S) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   comparator_bist_if #(.S(S), .SETTLE(SETTLE), .ERR_W(ERR_W)) bus ();

   comparator_bist #(.S(S), .SETTLE(SETTLE), .ERR_W(ERR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Comparator under test: ideal or GT stuck-at-0, with lat register stages.
   bit   stuck_gt = 0;
   int   lat      = 0;
   logic ceq, cgt;
   logic [3:1] peq, pgt;
   assign ceq = (bus.dut_a == bus.dut_b);
   assign cgt = stuck_gt ? 1'b0 : (bus.dut_a > bus.dut_b);
   always @(posedge clk) begin
      peq <= {peq[2:1], ceq};
      pgt <= {pgt[2:1], cgt};
   end
   always_comb begin
      bus.dut_eq = ceq;
      bus.dut_gt = cgt;
      case (lat)
         1: begin bus.dut_eq = peq[1]; bus.dut_gt = pgt[1]; end
         2: begin bus.dut_eq = peq[2]; bus.dut_gt = pgt[2]; end
         3: begin bus.dut_eq = peq[3]; bus.dut_gt = pgt[3]; end
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Result of the comparator for pair index p, as seen by the BIST.
   function automatic int cmp_fn(input int p, input bit stuck);
      int a, b;
      a = (p >> S) & MASK;
      b = p & MASK;
      return {30'd0, (a == b), (!stuck && (a > b))};
   endfunction

   // Sample k observes vector v's result only once k exceeds the pipeline depth;
   // earlier samples still show the previous pair's result.
   function automatic void eval_vec(input int v, input int prv, output bit bad, output int st);
      int lm;
      bit wrong;
      lm    = 0;
      wrong = 0;
      for (int k = 1; k <= SETTLE; k++) begin
         wrong = cmp_fn((k > lat) ? v : prv, stuck_gt) != cmp_fn(v, 1'b0);
         if (wrong) lm = k;
      end
      bad = wrong;
      st  = lm + 1;
   endfunction

   bit m_run, m_done, m_fv;
   int m_n, m_pair, m_prev0, m_err, m_ffa, m_ffb, m_max;

   initial begin
      int v, prv, st;
      bit bad;
      m_run = 0; m_done = 0; m_fv = 0; m_n = 0; m_pair = 0; m_prev0 = 0;
      m_err = 0; m_ffa = 0; m_ffb = 0; m_max = 0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_run = 0; m_done = 0; m_fv = 0; m_n = 0; m_pair = 0;
            m_err = 0; m_ffa = 0; m_ffb = 0; m_max = 0;
         end else if (!m_run && bus.start) begin
            m_run = 1; m_done = 0; m_n = 0; m_prev0 = m_pair;
            m_err = 0; m_fv = 0; m_max = 0;
         end else if (m_run) begin
            m_n++;
            if ((m_n - 1) % P == 0) m_pair = (m_n - 1) / P;
            if (m_n % P == 0) begin
               v   = m_n / P - 1;
               prv = (v == 0) ? m_prev0 : v - 1;
               eval_vec(v, prv, bad, st);
               if (bad) begin
                  m_err++;
                  if (!m_fv) begin
                     m_fv  = 1;
                     m_ffa = (v >> S) & MASK;
                     m_ffb = v & MASK;
                  end
               end else if (st > m_max) begin
                  m_max = st;
               end
               if (v == NV - 1) begin
                  m_run  = 0;
                  m_done = 1;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("busy",         bus.busy,         m_run);
            check("done",         bus.done,         m_done);
            check("pass",         bus.pass,         m_done && (m_err == 0));
            check("dut_a",        bus.dut_a,        (m_pair >> S) & MASK);
            check("dut_b",        bus.dut_b,        m_pair & MASK);
            check("err_count",    bus.err_count,    m_err);
            check("fail_valid",   bus.fail_valid,   m_fv);
            check("first_fail_a", bus.first_fail_a, m_fv ? m_ffa : bus.first_fail_a);
            check("first_fail_b", bus.first_fail_b, m_fv ? m_ffb : bus.first_fail_b);
            check("max_settle",   bus.max_settle,   m_max);
         end
      end
   end

   task automatic do_run(input bit mid_pulse, output int cnt);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      check("start_busy", bus.busy, 1);
      check("start_done_low", bus.done, 0);
      check("start_err_clr", bus.err_count, 0);
      cnt = 0;
      while (!bus.done && cnt < 500) begin
         @(posedge clk);
         #1;
         cnt++;
         if (mid_pulse && cnt == 10) bus.start = 1'b1;
         if (mid_pulse && cnt == 11) bus.start = 1'b0;
      end
   endtask

   task automatic check_clean(input string tag, input int cnt);
      check({tag, "_latency"},    cnt, 64);
      check({tag, "_err"},        bus.err_count, 0);
      check({tag, "_pass"},       bus.pass, 1);
      check({tag, "_fail_valid"}, bus.fail_valid, 0);
      check({tag, "_max_settle"}, bus.max_settle, 1);
   endtask

   initial begin
      int cnt;
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err_count, 0);
      check("rst_dut_a", bus.dut_a, 0);

      do_run(1'b0, cnt);
      check_clean("ideal", cnt);
      $display("run ideal: cycles=%0d err=%0d max_settle=%0d", cnt, bus.err_count, bus.max_settle);

      @(negedge clk) stuck_gt = 1;
      do_run(1'b0, cnt);
      check("stuck_err", bus.err_count, 6);
      check("stuck_ffa", bus.first_fail_a, 1);
      check("stuck_ffb", bus.first_fail_b, 0);
      check("stuck_fv", bus.fail_valid, 1);
      check("stuck_pass", bus.pass, 0);
      $display("run stuck_gt: cycles=%0d err=%0d first=(%0d,%0d)", cnt, bus.err_count,
               bus.first_fail_a, bus.first_fail_b);

      @(negedge clk) begin stuck_gt = 0; lat = 1; end
      do_run(1'b0, cnt);
      check("lat1_err", bus.err_count, 0);
      check("lat1_max_settle", bus.max_settle, 2);
      check("lat1_pass", bus.pass, 1);
      $display("run lat1: cycles=%0d err=%0d max_settle=%0d", cnt, bus.err_count, bus.max_settle);

      @(negedge clk) lat = 3;
      do_run(1'b0, cnt);
      check("lat3_err_nonzero", bus.err_count != 0, 1);
      check("lat3_pass", bus.pass, 0);
      $display("run lat3: cycles=%0d err=%0d", cnt, bus.err_count);

      @(negedge clk) lat = 0;
      do_run(1'b1, cnt);
      check_clean("midstart", cnt);
      $display("run mid-start pulse: cycles=%0d err=%0d", cnt, bus.err_count);

      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (19) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_pass", bus.pass, 0);
      check("arst_dut_a", bus.dut_a, 0);
      check("arst_dut_b", bus.dut_b, 0);
      check("arst_err", bus.err_count, 0);
      check("arst_fv", bus.fail_valid, 0);
      check("arst_max", bus.max_settle, 0);
      $display("mid-run reset: busy=%0d dut_a=%0d", bus.busy, bus.dut_a);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      do_run(1'b0, cnt);
      check_clean("after_reset", cnt);
      $display("run after reset: cycles=%0d err=%0d max_settle=%0d", cnt, bus.err_count,
               bus.max_settle);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
